// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch and data ports; ack arrives MEM_LATENCY+1 cycles after grant.
// Requesters hold req until ack. Data port wins conflicts unless MEM_ARB_ROUND_ROBIN_EN is defined.
module mem_port_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MEM_LATENCY = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_ack,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_data_in,
   output logic              mem_write,
   input  logic [DATA_W-1:0] mem_data_out,
   output logic              busy
);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t     state, state_nxt;
   logic [3:0] cnt;
   logic       last_grant;   // 1 = data port, 0 = instruction port
   logic       i_elig, d_elig, grant, grant_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      i_ack     = 1'b0;
      d_ack     = 1'b0;
      busy      = 1'b0;
      // The port being acked in RESP still holds req that cycle; keep it out of the next grant.
      i_elig = i_req && !(state == RESP && !last_grant);
      d_elig = d_req && !(state == RESP && last_grant);
      grant  = (state != WAIT) && (i_elig || d_elig);
`ifdef MEM_ARB_ROUND_ROBIN_EN
      grant_d = d_elig && (!i_elig || !last_grant);
`else
      grant_d = d_elig;
`endif
      case (state)
         IDLE:    if (grant) state_nxt = WAIT;
         WAIT:    begin
            busy = 1'b1;
            if (cnt == 4'd1) state_nxt = RESP;
         end
         RESP:    begin
            i_ack     = !last_grant;
            d_ack     = last_grant;
            state_nxt = grant ? WAIT : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= 4'd0;
         last_grant  <= 1'b0;
         mem_address <= '0;
         mem_data_in <= '0;
         mem_write   <= 1'b0;
         i_rdata     <= '0;
         d_rdata     <= '0;
      end else if (grant) begin
         mem_address <= grant_d ? d_addr : i_addr;
         if (grant_d) mem_data_in <= d_wdata;
         mem_write   <= grant_d && d_we;
         cnt         <= 4'(MEM_LATENCY);
         last_grant  <= grant_d;
      end else if (state == WAIT) begin
         mem_write <= 1'b0;
         cnt       <= cnt - 4'd1;
         if (cnt == 4'd1) begin
            if (last_grant) d_rdata <= mem_data_out;
            else            i_rdata <= mem_data_out;
         end
      end
   end
endmodule
